// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive stimulus sequencer: walks all 2^N_IN input vectors in binary or Gray
// order, captures each response over valid/ready and folds it into a MISR signature.
module exhaustive_vector_sequencer #(
    parameter int                N_IN      = 3,
    parameter int                N_OUT     = 1,
    parameter int                SETTLE    = 1,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              cap_valid,
    input  logic              cap_ready,
    output logic [N_IN-1:0]   cap_vector,
    output logic [N_OUT-1:0]  cap_response,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature
);

    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              mode_q;
    logic [N_IN-1:0]   cnt;
    logic [N_IN-1:0]   cnt_next;
    logic [SW-1:0]     settle_cnt;
    logic [MISR_W-1:0] misr_next;
    logic [MISR_W-1:0] resp_ext;
    logic              load_run;
    logic              do_capture;
    logic              do_handshake;
    logic              clear_run;

    function automatic logic [N_IN-1:0] vec_of(input logic [N_IN-1:0] c, input logic gray);
        return gray ? (c ^ (c >> 1)) : c;
    endfunction

    assign cnt_next  = cnt + N_IN'(1);
    assign resp_ext  = MISR_W'(cap_response);
    assign misr_next = {signature[MISR_W-2:0], 1'b0}
                     ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                     ^ resp_ext;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort beats a same-cycle handshake, so the MISR never absorbs a cancelled capture.
    always_comb begin
        next_state   = state;
        load_run     = 1'b0;
        do_capture   = 1'b0;
        do_handshake = 1'b0;
        clear_run    = 1'b0;
        cap_valid    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_run   = 1'b1;
                    next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    clear_run  = 1'b1;
                    next_state = S_IDLE;
                end else if (settle_cnt == '0) begin
                    do_capture = 1'b1;
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                cap_valid = 1'b1;
                if (abort) begin
                    clear_run  = 1'b1;
                    next_state = S_IDLE;
                end else if (cap_ready) begin
                    do_handshake = 1'b1;
                    next_state   = (cnt == LAST_VEC) ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
                if (abort) begin
                    clear_run = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            mode_q       <= 1'b0;
            cnt          <= '0;
            settle_cnt   <= '0;
            dut_in       <= '0;
            cap_vector   <= '0;
            cap_response <= '0;
            signature    <= MISR_SEED;
        end else if (load_run) begin
            mode_q     <= mode;
            cnt        <= '0;
            settle_cnt <= SETTLE_LOAD;
            dut_in     <= vec_of('0, mode);
            signature  <= MISR_SEED;
        end else if (clear_run) begin
            dut_in <= '0;
        end else if (do_capture) begin
            cap_response <= dut_out;
            cap_vector   <= dut_in;
        end else if (do_handshake) begin
            signature <= misr_next;
            if (cnt != LAST_VEC) begin
                cnt        <= cnt_next;
                dut_in     <= vec_of(cnt_next, mode_q);
                settle_cnt <= SETTLE_LOAD;
            end
        end else if (state == S_SETTLE) begin
            settle_cnt <= settle_cnt - SW'(1);
        end
    end

endmodule
